// File: rtl/caesar_pkg.sv
// Shared constants, key record and letter-shift arithmetic for the Caesar cipher pipeline.
package caesar_pkg;

  localparam int KEY_W      = 5;
  localparam int ALPHA_SIZE = 26;

  localparam logic [7:0] UPPER_A = 8'h41;
  localparam logic [7:0] UPPER_Z = 8'h5A;
  localparam logic [7:0] LOWER_A = 8'h61;
  localparam logic [7:0] LOWER_Z = 8'h7A;

  typedef struct packed {
    logic [KEY_W-1:0] shift;
    logic             dir;    // 0 = right (+), 1 = left (-)
  } key_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= UPPER_A) && (c <= UPPER_Z)) || ((c >= LOWER_A) && (c <= LOWER_Z));
  endfunction

  // Non-letters come back unchanged; the caller decides how to flag them.
  function automatic logic [7:0] shift_letter(input logic [7:0] c,
                                              input logic [KEY_W-1:0] shift,
                                              input logic dir);
    logic [7:0] base;
    logic [4:0] off;
    logic [5:0] s;
    if ((c >= UPPER_A) && (c <= UPPER_Z)) begin
      base = UPPER_A;
    end else if ((c >= LOWER_A) && (c <= LOWER_Z)) begin
      base = LOWER_A;
    end else begin
      return c;
    end
    off = 5'(c - base);
    if (!dir) begin
      s = {1'b0, off} + 6'(shift);
      if (s >= 6'(ALPHA_SIZE)) s = s - 6'(ALPHA_SIZE);
    end else if (off >= 5'(shift)) begin
      s = {1'b0, off} - 6'(shift);
    end else begin
      s = {1'b0, off} + 6'(ALPHA_SIZE) - 6'(shift);
    end
    return base + {2'b00, s};
  endfunction

endpackage

// File: rtl/caesar_cipher_pipe_stage.sv
// One registered cipher round: applies its key to the beat when the pipeline advances.
module caesar_shift_stage
  import caesar_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  input  logic       in_decrypt,
  input  logic       in_err,
  input  key_t       key,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_decrypt,
  output logic       out_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_char    <= 8'h00;
      out_decrypt <= 1'b0;
      out_err     <= 1'b0;
    end else if (en) begin
      out_valid   <= in_valid;
      out_char    <= shift_letter(in_char, key.shift, key.dir);
      out_decrypt <= in_decrypt;
      out_err     <= in_err;
    end
  end

endmodule

// File: rtl/caesar_cipher_pipe.sv
// N-round Caesar cipher pipeline with runtime key file and valid/ready streaming.
// Build option CAESAR_PASSTHROUGH_EN: non-letters pass through unchanged instead of
// being replaced by 8'h00 with out_err set.
module caesar_cipher_pipe
  import caesar_pkg::*;
#(
  parameter  int NUM_STAGES = 3,
  parameter  int KEY_W      = 5,
  localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [KEY_W-1:0] cfg_shift,
  input  logic             cfg_dir,
  output logic             cfg_err,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_err
);

  localparam int NS    = NUM_STAGES;
  localparam int OCC_W = $clog2(NS + 1);

  // Handshake: a beat moves on a clock edge when valid && ready are both high.
  // The whole pipeline advances together (en) whenever the output slot is empty or
  // being drained; bubbles are carried, not collapsed, so in_ready is simply en.
  logic en;
  logic accept;
  logic out_hs;

  key_t             keys [NS];
  key_t             stage_key [NS];
  logic             v   [NS+1];
  logic [7:0]       ch  [NS+1];
  logic             dec [NS+1];
  logic             err [NS+1];
  logic [OCC_W-1:0] occ;
  logic             cfg_reject;
  logic             unused_dec;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign out_hs   = out_valid && out_ready;

  // Stage-0 inputs: non-letters are flagged once here and then ride through untouched.
  always_comb begin
    v[0]   = in_valid;
    dec[0] = in_decrypt;
`ifdef CAESAR_PASSTHROUGH_EN
    ch[0]  = in_char;
    err[0] = 1'b0;
`else
    ch[0]  = is_letter(in_char) ? in_char : 8'h00;
    err[0] = !is_letter(in_char);
`endif
  end

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_stage
      // Decrypt walks the keys in reverse order with each direction flipped.
      assign stage_key[g] = dec[g] ? key_t'({keys[NS-1-g].shift, ~keys[NS-1-g].dir})
                                   : keys[g];

      caesar_shift_stage u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_valid    (v[g]),
        .in_char     (ch[g]),
        .in_decrypt  (dec[g]),
        .in_err      (err[g]),
        .key         (stage_key[g]),
        .out_valid   (v[g+1]),
        .out_char    (ch[g+1]),
        .out_decrypt (dec[g+1]),
        .out_err     (err[g+1])
      );
    end
  endgenerate

  assign out_valid  = v[NS];
  assign out_char   = ch[NS];
  assign out_err    = err[NS];
  assign unused_dec = dec[NS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (accept && !out_hs) begin
      occ <= occ + OCC_W'(1);
    end else if (!accept && out_hs) begin
      occ <= occ - OCC_W'(1);
    end
  end

  assign busy = (occ != '0);

  // Keys may only change while nothing is in flight, so every beat sees one key set.
  assign cfg_reject = (cfg_shift > (KEY_W)'(ALPHA_SIZE - 1)) ||
                      (int'(cfg_idx) >= NS) || busy || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      for (int k = 0; k < NS; k++) keys[k] <= '0;
    end else begin
      cfg_err <= cfg_we && cfg_reject;
      if (cfg_we && !cfg_reject) begin
        for (int k = 0; k < NS; k++) begin
          if (int'(cfg_idx) == k) keys[k] <= {cfg_shift, cfg_dir};
        end
      end
    end
  end

endmodule

// File: tb/tb_caesar_cipher_pipe.sv
// Self-checking bench for caesar_cipher_pipe: directed scenarios plus randomized traffic
// scored against a net-rotation reference model.
module tb_caesar_cipher_pipe;

  localparam int NS    = 3;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [4:0]       cfg_shift;
  logic             cfg_dir;
  logic             cfg_err;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             in_decrypt;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_err;

  caesar_cipher_pipe #(.NUM_STAGES(NS), .KEY_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_shift  (cfg_shift),
    .cfg_dir    (cfg_dir),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_decrypt (in_decrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .out_err    (out_err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  int         m_shift [NS];
  bit         m_dir   [NS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the whole pipeline is one rotation by the signed sum of round keys.
  function automatic logic [8:0] model(input logic [7:0] c, input logic d);
    int net;
    int base;
    int r;
    net = 0;
    for (int i = 0; i < NS; i++) net += m_dir[i] ? -m_shift[i] : m_shift[i];
    if (d) net = -net;
    if (c >= 8'd65 && c <= 8'd90)       base = 65;
    else if (c >= 8'd97 && c <= 8'd122) base = 97;
    else                                base = -1;
    if (base < 0) begin
`ifdef CAESAR_PASSTHROUGH_EN
      return {1'b0, c};
`else
      return {1'b1, 8'h00};
`endif
    end
    r = ((int'(c) - base + net) % 26 + 26) % 26;
    return {1'b0, 8'(base + r)};
  endfunction

  // scoreboard: push on accept, pop and compare on output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_char", {24'd0, out_char}, {24'd0, e[7:0]});
          check("out_err", {31'd0, out_err}, {31'd0, e[8]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_char, in_decrypt));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int idx, input int sh, input bit dir);
    bit rej;
    cfg_we    = 1'b1;
    cfg_idx   = IDX_W'(idx);
    cfg_shift = 5'(sh);
    cfg_dir   = dir;
    rej = (sh > 25) || (idx >= NS) || (exp_q.size() != 0) || (in_valid && in_ready);
    tick();
    cfg_we = 1'b0;
    check("cfg_err", {31'd0, cfg_err}, {31'd0, rej});
    if (!rej) begin
      m_shift[idx] = sh;
      m_dir[idx]   = dir;
    end
  endtask

  task automatic send_beat(input logic [7:0] c, input logic d);
    bit acc;
    int k;
    in_valid   = 1'b1;
    in_char    = c;
    in_decrypt = d;
    k = 0;
    do begin
      acc = in_ready;
      tick();
      k++;
    end while (!acc && k < 50);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  // Measures accept-to-out_valid latency in cycles with out_ready held high.
  task automatic latency_beat(input logic [7:0] c, input logic d, input logic [7:0] exp_c,
                              input string tag);
    int n;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_char    = c;
    in_decrypt = d;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({tag, "_lat"}, n, NS);
    check({tag, "_char"}, {24'd0, out_char}, {24'd0, exp_c});
    tick();
  endtask

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 3))
      0:       return 8'(65 + $urandom_range(0, 25));
      1:       return 8'(97 + $urandom_range(0, 25));
      2:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  initial begin
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_shift  = '0;
    cfg_dir    = 1'b0;
    in_valid   = 1'b0;
    in_char    = 8'h00;
    in_decrypt = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < NS; i++) begin
      m_shift[i] = 0;
      m_dir[i]   = 1'b0;
    end
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_char", {24'd0, out_char}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // keys {3,R},{5,L},{1,R}; encrypt and decrypt latency
    write_key(0, 3, 1'b0);
    write_key(1, 5, 1'b1);
    write_key(2, 1, 1'b0);
    latency_beat(8'h41, 1'b0, 8'h5A, "enc_A");
    latency_beat(8'h5A, 1'b1, 8'h41, "dec_Z");
    drain();

    // back-to-back y, a, Z
    out_ready = 1'b1;
    send_beat(8'h79, 1'b0);
    send_beat(8'h61, 1'b0);
    send_beat(8'h5A, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_v0", {31'd0, out_valid}, 32'd1);
    check("b2b_c0", {24'd0, out_char}, 32'h78);
    @(negedge clk);
    check("b2b_v1", {31'd0, out_valid}, 32'd1);
    check("b2b_c1", {24'd0, out_char}, 32'h7A);
    @(negedge clk);
    check("b2b_v2", {31'd0, out_valid}, 32'd1);
    check("b2b_c2", {24'd0, out_char}, 32'h59);
    tick();
    drain();

    // backpressure with three beats in flight
    out_ready = 1'b0;
    send_beat(8'h48, 1'b0);
    send_beat(8'h69, 1'b1);
    send_beat(8'h2A, 1'b0);
    in_valid = 1'b1;
    in_char  = 8'h51;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_char", {24'd0, out_char}, {24'd0, exp_q[0][7:0]});
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    in_valid = 1'b0;
    drain();

    // key write rejection cases
    write_key(0, 26, 1'b0);
    write_key(3, 4, 1'b0);
    send_beat(8'h62, 1'b0);
    in_valid = 1'b0;
    write_key(1, 2, 1'b0);
    drain();
    in_valid = 1'b1;
    in_char  = 8'h63;
    write_key(2, 4, 1'b1);
    in_valid = 1'b0;
    drain();
    latency_beat(8'h41, 1'b0, 8'h5A, "keys_kept");

    // non-letter handling
`ifdef CAESAR_PASSTHROUGH_EN
    latency_beat(8'h35, 1'b0, 8'h35, "digit");
    check("digit_err", {31'd0, out_err}, 32'd0);
`else
    latency_beat(8'h35, 1'b0, 8'h00, "digit");
`endif
    drain();

    // randomized traffic with occasional key writes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NS; i++) write_key(i, $urandom_range(0, 25), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 150; c++) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_char    = rand_char();
        in_decrypt = 1'($urandom_range(0, 1));
        out_ready  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0)
          write_key($urandom_range(0, 3), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
        else
          tick();
      end
      drain();
    end

    // reset with two beats in flight
    write_key(0, 7, 1'b0);
    out_ready = 1'b1;
    send_beat(8'h4B, 1'b0);
    send_beat(8'h6C, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      m_shift[i] = 0;
      m_dir[i]   = 1'b0;
    end
    #2;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out_char", {24'd0, out_char}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    latency_beat(8'h41, 1'b0, 8'h41, "post_rst");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
